ay_frame_sequencer: RTL and testbench

- Autonomous register-frame player for the ay8913 PSG write port.
- Host fills a 14-entry shadow frame buffer. On each programmable frame tick, the block streams only the changed ("dirty") registers into the PSG, one register per cycle.
- Direct host writes share the same PSG write port and always win arbitration.
- Sits between the peripheral bus decode and the ay8913 instance, in place of the direct data_write/address/data_in hookup.

---
 rtl/ay_seq_pkg.sv | 21 ++
 rtl/ay_frame_sequencer_if.sv | 37 +++
 rtl/ay_frame_timer.sv | 42 ++++
 rtl/ay_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ay_frame_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ay_seq_pkg.sv
// -----------------------------------------------------------------------------
// ay_seq_pkg
// Shared constants and types for the AY-3-8913 frame sequencer.
//   NUM_REGS : number of PSG registers mirrored in the shadow frame buffer
//   IDX_W    : width of a PSG register index
//   LAST_IDX : last register visited by a scan (envelope shape register)
//   state_e  : sequencer state (IDLE waiting for a frame tick, SCAN streaming)
// -----------------------------------------------------------------------------
package ay_seq_pkg;

  localparam int NUM_REGS = 14;
  localparam int IDX_W    = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage : ay_seq_pkg

// File: rtl/ay_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// ay_frame_sequencer_if
// Bus bundle between the peripheral decode, the sequencer and the PSG.
//   host_write/host_addr/host_data : direct PSG write (priority path)
//   buf_write/buf_addr/buf_data    : shadow frame buffer write
//   psg_write/psg_addr/psg_data    : arbitrated write port towards the ay8913
// Modports:
//   master : bus-decode side (drives host/buf, observes psg)
//   slave  : sequencer side (consumes host/buf, drives psg)
// -----------------------------------------------------------------------------
interface ay_frame_sequencer_if;

  logic       host_write;
  logic [3:0] host_addr;
  logic [7:0] host_data;

  logic       buf_write;
  logic [3:0] buf_addr;
  logic [7:0] buf_data;

  logic       psg_write;
  logic [3:0] psg_addr;
  logic [7:0] psg_data;

  modport master (
    output host_write, host_addr, host_data,
    output buf_write, buf_addr, buf_data,
    input  psg_write, psg_addr, psg_data
  );

  modport slave (
    input  host_write, host_addr, host_data,
    input  buf_write, buf_addr, buf_data,
    output psg_write, psg_addr, psg_data
  );

endinterface : ay_frame_sequencer_if

// File: rtl/ay_frame_timer.sv
// -----------------------------------------------------------------------------
// ay_frame_timer
// Programmable frame tick generator (down-counter with reload).
//   clk, rst_n   : clock, synchronous active-low reset
//   enable       : run the timer; when low the counter is held at zero
//   frame_period : clocks per frame; zero disables ticking
//   tick         : one-cycle frame tick, high while the counter sits at zero
// Because the counter idles at zero, the first tick lands on the first
// enabled cycle, then every frame_period cycles after that.
// -----------------------------------------------------------------------------
module ay_frame_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] frame_period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count_q, count_d;
  logic                running;

  assign running = enable && (frame_period != '0);
  assign tick    = running && (count_q == '0);

  // NOTE: always_comb gives every output a default first so no path can
  // leave count_d unassigned and infer a latch.
  always_comb begin
    count_d = '0;
    if (running) begin
      if (count_q == '0) count_d = frame_period - 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule : ay_frame_timer

// File: rtl/ay_frame_sequencer.sv
// -----------------------------------------------------------------------------
// ay_frame_sequencer
// Autonomous register-frame player for the ay8913 write port. The host fills
// a 14-entry shadow buffer; on each frame tick only the registers written
// since the last scan ("dirty") are streamed into the PSG, one per cycle.
// Direct host writes share the PSG port and always win arbitration.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : host direct write, shadow buffer write, PSG write port
//   enable       : frame playback enable
//   frame_period : clocks per frame (0 = no ticks)
//   overrun_clr  : clears the sticky overrun flag
//   busy         : high while scanning
//   frame_done   : one-cycle pulse after the last register of a scan
//   overrun      : sticky, a tick arrived while a scan was still running
// All outputs are registered: psg_* follow the arbitration decision by one
// cycle and hold address/data when no write is issued.
// -----------------------------------------------------------------------------
module ay_frame_sequencer
  import ay_seq_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ay_frame_sequencer_if.slave  bus,
  input  logic                 enable,
  input  logic [PERIOD_W-1:0]  frame_period,
  input  logic                 overrun_clr,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  // ---------------------------------------------------------------------------
  // Frame timer
  // ---------------------------------------------------------------------------
  logic tick;

  ay_frame_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .frame_period (frame_period),
    .tick         (tick)
  );

  // ---------------------------------------------------------------------------
  // Shadow buffer and dirty tracking
  // ---------------------------------------------------------------------------
  logic [7:0]          shadow_q [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [NUM_REGS-1:0] dirty_set, dirty_clr;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;

  logic                buf_hit;
  logic                stream;

  // Indices 14 and 15 have no shadow entry and are silently dropped.
  assign buf_hit = bus.buf_write && (bus.buf_addr < IDX_W'(NUM_REGS));

  // A shadow entry is streamed only when no host write contends for the port.
  assign stream  = (state_q == SCAN) && !bus.host_write && dirty_q[idx_q];

  // Set beats clear: a buffer write landing on the entry being streamed keeps
  // it dirty so the new value goes out on the next frame.
  always_comb begin
    dirty_set = '0;
    dirty_clr = '0;
    if (buf_hit) dirty_set[bus.buf_addr] = 1'b1;
    if (stream)  dirty_clr[idx_q]        = 1'b1;
    dirty_d = (dirty_q & ~dirty_clr) | dirty_set;
  end

  // NOTE: the shadow array is reset explicitly because a cleared buffer is
  // part of the block's defined power-up state, not just the dirty bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
      dirty_q <= '0;
    end else begin
      if (buf_hit) shadow_q[bus.buf_addr] <= bus.buf_data;
      dirty_q <= dirty_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic       psg_write_q;
  logic [3:0] psg_addr_q;
  logic [7:0] psg_data_q;
  logic       busy_q;
  logic       frame_done_q;
  logic       overrun_q;

  // NOTE: sequential state uses non-blocking assignments only; the defaults
  // at the top of the block are overridden later in the same cycle, which is
  // well defined because the last non-blocking write wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      psg_write_q  <= 1'b0;
      psg_addr_q   <= '0;
      psg_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      psg_write_q  <= 1'b0;
      frame_done_q <= 1'b0;

      // Write port arbitration: host first, then the streamed shadow entry.
      if (bus.host_write) begin
        psg_write_q <= 1'b1;
        psg_addr_q  <= bus.host_addr;
        psg_data_q  <= bus.host_data;
      end else if (stream) begin
        psg_write_q <= 1'b1;
        psg_addr_q  <= idx_q;
        psg_data_q  <= shadow_q[idx_q];
      end

      unique case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          // A contending host write stalls the scan on the current index.
          if (!bus.host_write) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= IDLE;
              idx_q        <= '0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Ticks arriving mid-scan are dropped but flagged; a set beats a clear.
      if ((state_q == SCAN) && tick) overrun_q <= 1'b1;
      else if (overrun_clr)          overrun_q <= 1'b0;
    end
  end

  assign bus.psg_write = psg_write_q;
  assign bus.psg_addr  = psg_addr_q;
  assign bus.psg_data  = psg_data_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign overrun       = overrun_q;

endmodule : ay_frame_sequencer

// File: tb/tb_ay_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ay_frame_sequencer
// Directed bench for ay_frame_sequencer. Inputs change just after a falling
// edge and outputs are sampled on the next falling edge, so "sample s" shows
// the state after the rising edge that ends cycle s. A frame tick in cycle 0
// therefore shows busy from sample 0 to 13, the write of register k at sample
// k+1 and frame_done at sample 14.
// -----------------------------------------------------------------------------
module tb_ay_frame_sequencer;
  import ay_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] frame_period;
  logic        overrun_clr;
  logic        busy, frame_done, overrun;

  ay_frame_sequencer_if bus ();

  ay_frame_sequencer #(.PERIOD_W(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .enable       (enable),
    .frame_period (frame_period),
    .overrun_clr  (overrun_clr),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model of the shadow buffer as the host sees it.
  logic [7:0]  m_shadow [NUM_REGS];
  logic [13:0] m_dirty;

  typedef struct {
    logic       hw;
    logic [3:0] ha;
    logic [7:0] hd;
    logic       ew;
    logic [3:0] ea;
    logic [7:0] ed;
  } host_vec_t;

  host_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic buf_wr(input logic [3:0] a, input logic [7:0] d);
    bus.buf_write = 1'b1;
    bus.buf_addr  = a;
    bus.buf_data  = d;
    sample();
    bus.buf_write = 1'b0;
    if (a < 4'd14) begin
      m_shadow[a] = d;
      m_dirty[a]  = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = 8'h00;
    m_dirty = '0;
  endtask

  // Checks one undisturbed scan whose tick falls in the cycle about to run.
  task automatic scan_check(input string tag);
    logic exp_w;
    for (int s = 0; s < 16; s++) begin
      sample();
      exp_w = (s >= 1) && (s <= 14) && m_dirty[s-1];
      check($sformatf("%s psg_write s%0d", tag, s), 32'(bus.psg_write), 32'(exp_w));
      if (exp_w) begin
        check($sformatf("%s psg_addr_data s%0d", tag, s),
              {20'h0, bus.psg_addr, bus.psg_data}, {20'h0, 4'(s - 1), m_shadow[s-1]});
        m_dirty[s-1] = 1'b0;
      end
      check($sformatf("%s busy s%0d", tag, s), 32'(busy), 32'(s <= 13));
      check($sformatf("%s frame_done s%0d", tag, s), 32'(frame_done), 32'(s == 14));
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nwr;
    logic [3:0] ea;
    logic [7:0] ed;
    logic       ew;

    vecs[0] = '{hw: 1'b1, ha: 4'd3,  hd: 8'hA5, ew: 1'b1, ea: 4'd3,  ed: 8'hA5};
    vecs[1] = '{hw: 1'b0, ha: 4'd9,  hd: 8'h00, ew: 1'b0, ea: 4'd3,  ed: 8'hA5};
    vecs[2] = '{hw: 1'b1, ha: 4'd15, hd: 8'hFF, ew: 1'b1, ea: 4'd15, ed: 8'hFF};
    vecs[3] = '{hw: 1'b1, ha: 4'd0,  hd: 8'h01, ew: 1'b1, ea: 4'd0,  ed: 8'h01};
    vecs[4] = '{hw: 1'b0, ha: 4'd5,  hd: 8'h77, ew: 1'b0, ea: 4'd0,  ed: 8'h01};
    vecs[5] = '{hw: 1'b1, ha: 4'd13, hd: 8'h0E, ew: 1'b1, ea: 4'd13, ed: 8'h0E};

    rst_n          = 1'b0;
    enable         = 1'b0;
    frame_period   = 24'd100;
    overrun_clr    = 1'b0;
    bus.host_write = 1'b0;
    bus.host_addr  = '0;
    bus.host_data  = '0;
    bus.buf_write  = 1'b0;
    bus.buf_addr   = '0;
    bus.buf_data   = '0;
    model_reset();

    // Reset state
    sample();
    sample();
    check("reset psg_write", 32'(bus.psg_write), 32'd0);
    check("reset psg_addr_data", {20'h0, bus.psg_addr, bus.psg_data}, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    sample();

    // Host path while idle: one-cycle latency, address/data hold when idle.
    for (int i = 0; i < 6; i++) begin
      bus.host_write = vecs[i].hw;
      bus.host_addr  = vecs[i].ha;
      bus.host_data  = vecs[i].hd;
      sample();
      check($sformatf("host v%0d psg_write", i), 32'(bus.psg_write), 32'(vecs[i].ew));
      check($sformatf("host v%0d psg_addr_data", i),
            {20'h0, bus.psg_addr, bus.psg_data}, {20'h0, vecs[i].ea, vecs[i].ed});
      check($sformatf("host v%0d busy", i), 32'(busy), 32'd0);
    end
    bus.host_write = 1'b0;
    sample();

    // Free-running frames with nothing dirty: ticks at cycles 0, 100, 200.
    frame_period = 24'd100;
    enable       = 1'b1;
    for (int f = 0; f < 3; f++) begin
      scan_check($sformatf("empty f%0d", f));
      if (f < 2) begin
        for (int s = 16; s < 100; s++) begin
          sample();
          check($sformatf("empty f%0d gap busy s%0d", f, s), 32'(busy), 32'd0);
          check($sformatf("empty f%0d gap psg_write s%0d", f, s), 32'(bus.psg_write), 32'd0);
        end
      end
    end
    enable = 1'b0;
    sample();

    // Three dirty registers, then a clean frame.
    buf_wr(4'd0, 8'h55);
    buf_wr(4'd7, 8'h38);
    buf_wr(4'd13, 8'h0E);
    enable = 1'b1;
    scan_check("dirty3");
    for (int s = 16; s < 100; s++) begin
      sample();
      check($sformatf("dirty3 gap psg_write s%0d", s), 32'(bus.psg_write), 32'd0);
    end
    scan_check("clean");
    enable = 1'b0;
    sample();

    // Host write contending at the slot where register 3 would go out.
    for (int i = 0; i < NUM_REGS; i++) buf_wr(4'(i), 8'(8'h20 + i));
    enable = 1'b1;
    nwr    = 0;
    for (int s = 0; s < 16; s++) begin
      sample();
      ew = (s >= 1);
      if (s == 4)                  begin ea = 4'd8;        ed = 8'h0F;          end
      else if (s >= 1 && s < 4)    begin ea = 4'(s - 1);   ed = 8'(8'h20 + s - 1); end
      else                         begin ea = 4'(s - 2);   ed = 8'(8'h20 + s - 2); end
      if (bus.psg_write) nwr++;
      check($sformatf("contend psg_write s%0d", s), 32'(bus.psg_write), 32'(ew));
      if (ew) check($sformatf("contend psg_addr_data s%0d", s),
                    {20'h0, bus.psg_addr, bus.psg_data}, {20'h0, ea, ed});
      check($sformatf("contend busy s%0d", s), 32'(busy), 32'(s <= 14));
      check($sformatf("contend frame_done s%0d", s), 32'(frame_done), 32'(s == 15));
      bus.host_write = (s == 3);
      bus.host_addr  = 4'd8;
      bus.host_data  = 8'h0F;
    end
    check("contend write count", 32'(nwr), 32'd15);
    m_dirty = '0;
    enable  = 1'b0;
    sample();

    // Buffer write to the entry being streamed: old value now, new next frame.
    buf_wr(4'd5, 8'h11);
    enable = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sample();
      check($sformatf("collide psg_write s%0d", s), 32'(bus.psg_write), 32'(s == 6));
      if (s == 6) check("collide psg_addr_data",
                        {20'h0, bus.psg_addr, bus.psg_data}, {20'h0, 4'd5, 8'h11});
      check($sformatf("collide busy s%0d", s), 32'(busy), 32'(s <= 13));
      check($sformatf("collide frame_done s%0d", s), 32'(frame_done), 32'(s == 14));
      bus.buf_write = (s == 5);
      bus.buf_addr  = 4'd5;
      bus.buf_data  = 8'hAA;
    end
    m_shadow[5] = 8'hAA;
    m_dirty[5]  = 1'b1;
    enable = 1'b0;
    buf_wr(4'd14, 8'hFF);
    buf_wr(4'd15, 8'hEE);
    sample();
    enable = 1'b1;
    scan_check("collide next");
    enable = 1'b0;
    sample();

    // Overrun: host write held high stalls the scan across later ticks.
    frame_period   = 24'd10;
    bus.host_write = 1'b1;
    bus.host_addr  = 4'd2;
    bus.host_data  = 8'h33;
    enable         = 1'b1;
    for (int s = 0; s < 22; s++) begin
      sample();
      check($sformatf("ovr psg_write s%0d", s), 32'(bus.psg_write), 32'd1);
      check($sformatf("ovr busy s%0d", s), 32'(busy), 32'd1);
      if (s == 9)  check("ovr before 2nd tick", 32'(overrun), 32'd0);
      if (s == 10) check("ovr after 2nd tick", 32'(overrun), 32'd1);
      if (s == 11) check("ovr clr no tick", 32'(overrun), 32'd0);
      if (s == 20) check("ovr set beats clr", 32'(overrun), 32'd1);
      if (s == 21) check("ovr clr again", 32'(overrun), 32'd0);
      overrun_clr = (s == 10) || (s == 19) || (s == 20);
    end
    // Release the host and drop enable: the stalled scan runs to completion.
    bus.host_write = 1'b0;
    enable         = 1'b0;
    overrun_clr    = 1'b0;
    for (int s = 22; s < 60; s++) begin
      sample();
      check($sformatf("drain busy s%0d", s), 32'(busy), 32'(s <= 34));
      check($sformatf("drain frame_done s%0d", s), 32'(frame_done), 32'(s == 35));
      check($sformatf("drain psg_write s%0d", s), 32'(bus.psg_write), 32'd0);
      check($sformatf("drain overrun s%0d", s), 32'(overrun), 32'd0);
    end

    // Reset in the middle of a scan with everything dirty.
    frame_period = 24'd100;
    for (int i = 0; i < NUM_REGS; i++) buf_wr(4'(i), 8'(8'h40 + i));
    enable = 1'b1;
    for (int s = 0; s < 5; s++) sample();
    check("prerst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    sample();
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst psg_write", 32'(bus.psg_write), 32'd0);
    check("midrst psg_addr_data", {20'h0, bus.psg_addr, bus.psg_data}, 32'd0);
    check("midrst frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    model_reset();
    scan_check("postrst");
    enable = 1'b0;
    buf_wr(4'd13, 8'h0A);
    enable = 1'b1;
    scan_check("fresh");
    enable = 1'b0;
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ay_frame_sequencer
